// File: rtl/ws2811_strip_driver.sv
// ws2811_strip_driver: frame buffer plus one-wire serialiser for WS2811/WS2812 strips.
// A start request sends min(led_count, MAX_LEDS) 24-bit words MSB first, then holds
// the line low for the latch gap and pulses frame_done.
// Optional build macro: WS2811_BRIGHTNESS_EN adds a global brightness scaler applied at load.
module ws2811_strip_driver #(
    parameter int MAX_LEDS     = 64,
    parameter int T0H          = 25,
    parameter int T1H          = 60,
    parameter int TBIT         = 125,
    parameter int RESET_CYCLES = 80000,
    localparam int AW = $clog2(MAX_LEDS),
    localparam int CW = $clog2(((TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES) + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [23:0]   wr_rgb,
    input  logic [AW:0]   led_count,
    input  logic          start,
`ifdef WS2811_BRIGHTNESS_EN
    input  logic [7:0]    brightness,
`endif
    output logic          busy,
    output logic          frame_done,
    output logic          serial,
    output logic [2:0]    db_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_BIT_HI = 3'd2,
        ST_BIT_LO = 3'd3,
        ST_NEXT   = 3'd4,
        ST_LATCH  = 3'd5
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   hi_len_s;
    logic [CW-1:0]   lo_len_s;
    logic            phase_end_s;
    logic [AW:0]     n_start_s;
    logic [AW:0]     n_r;
    logic [AW-1:0]   led_idx_r;
    logic [4:0]      bit_idx_r;
    logic [23:0]     shreg_r;
    logic [23:0]     load_word_s;
    logic            last_led_s;
    logic            serial_r;
    logic            busy_r;
    logic            frame_done_r;
    logic [23:0]     mem_r [MAX_LEDS];

`ifdef WS2811_BRIGHTNESS_EN
    logic [7:0]      bright_r;

    // Scale each 8-bit channel by (b+1)/256 so that 255 is a pass-through and 0 blanks.
    function automatic logic [23:0] scale_word(input logic [23:0] w, input logic [7:0] b);
        logic [15:0] p;
        logic [23:0] r;
        r = 24'd0;
        for (int c = 0; c < 3; c++) begin
            p = {8'd0, w[c*8 +: 8]} * ({8'd0, b} + 16'd1);
            r[c*8 +: 8] = p[15:8];
        end
        return r;
    endfunction
`endif

    // Frame buffer write port; not reset so it maps onto RAM, out-of-range indices dropped.
    always_ff @(posedge clock) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MAX_LEDS))) begin
            mem_r[wr_addr] <= wr_rgb;
        end
    end

    // Clamp requested LED count, pick the current bit's high time and the word to load.
    always_comb begin
        if (led_count > (AW+1)'(MAX_LEDS)) begin
            n_start_s = (AW+1)'(MAX_LEDS);
        end else begin
            n_start_s = led_count;
        end
        hi_len_s   = shreg_r[23] ? CW'(T1H) : CW'(T0H);
        lo_len_s   = CW'(TBIT) - hi_len_s;
        last_led_s = ({1'b0, led_idx_r} == (n_r - (AW+1)'(1)));
`ifdef WS2811_BRIGHTNESS_EN
        load_word_s = scale_word(mem_r[led_idx_r], bright_r);
`else
        load_word_s = mem_r[led_idx_r];
`endif
    end

    // Next-state logic; phase_end_s marks the final cycle of a timed phase.
    always_comb begin
        next_s      = state_r;
        phase_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = (n_start_s == (AW+1)'(0)) ? ST_LATCH : ST_LOAD;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                next_s = ST_BIT_HI;
            end
            ST_BIT_HI: begin
                if (cnt_r == hi_len_s - CW'(1)) begin
                    phase_end_s = 1'b1;
                    next_s      = ST_BIT_LO;
                end else begin
                    next_s = ST_BIT_HI;
                end
            end
            ST_BIT_LO: begin
                if (cnt_r == lo_len_s - CW'(1)) begin
                    phase_end_s = 1'b1;
                    next_s      = (bit_idx_r == 5'd0) ? ST_NEXT : ST_BIT_HI;
                end else begin
                    next_s = ST_BIT_LO;
                end
            end
            ST_NEXT: begin
                next_s = last_led_s ? ST_LATCH : ST_LOAD;
            end
            ST_LATCH: begin
                if (cnt_r == CW'(RESET_CYCLES - 1)) begin
                    phase_end_s = 1'b1;
                    next_s      = ST_IDLE;
                end else begin
                    next_s = ST_LATCH;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            n_r          <= {(AW+1){1'b0}};
            led_idx_r    <= {AW{1'b0}};
            bit_idx_r    <= 5'd0;
            shreg_r      <= 24'd0;
            serial_r     <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef WS2811_BRIGHTNESS_EN
            bright_r     <= 8'd0;
`endif
        end else begin
            state_r <= next_s;
            if ((state_r == ST_IDLE) || (next_s != state_r)) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        n_r       <= n_start_s;
                        led_idx_r <= {AW{1'b0}};
`ifdef WS2811_BRIGHTNESS_EN
                        bright_r  <= brightness;
`endif
                    end
                end
                ST_LOAD: begin
                    shreg_r   <= load_word_s;
                    bit_idx_r <= 5'd23;
                end
                ST_BIT_LO: begin
                    if (phase_end_s) begin
                        shreg_r <= {shreg_r[22:0], 1'b0};
                        if (bit_idx_r != 5'd0) begin
                            bit_idx_r <= bit_idx_r - 5'd1;
                        end
                    end
                end
                ST_NEXT: begin
                    if (!last_led_s) begin
                        led_idx_r <= led_idx_r + AW'(1);
                    end
                end
                default: begin
                    shreg_r <= shreg_r;
                end
            endcase
            serial_r     <= (next_s == ST_BIT_HI);
            busy_r       <= (next_s != ST_IDLE);
            frame_done_r <= (state_r == ST_LATCH) && phase_end_s;
        end
    end

    assign serial     = serial_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign db_state   = state_r;

endmodule

// File: tb/tb_ws2811_strip_driver.sv
// Scoreboard bench for ws2811_strip_driver (T0H=2, T1H=5, TBIT=8, RESET_CYCLES=20, MAX_LEDS=4).
// Stimulus pushes expected words and frame lengths; a waveform monitor decodes the serial line.
module tb_ws2811_strip_driver;

    localparam int NLED = 4;
    localparam int FRAME_PER_LED = 194;   // LOAD + 24 bits of 8 cycles + NEXT
    localparam int LATCH_LEN = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_rgb;
    logic [2:0]  led_count;
    logic        start;
    logic        busy;
    logic        frame_done;
    logic        serial;
    logic [2:0]  db_state;
`ifdef WS2811_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'd127;
`endif

    ws2811_strip_driver #(
        .MAX_LEDS(4), .T0H(2), .T1H(5), .TBIT(8), .RESET_CYCLES(20)
    ) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_rgb(wr_rgb), .led_count(led_count), .start(start),
`ifdef WS2811_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy(busy), .frame_done(frame_done), .serial(serial), .db_state(db_state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;
    int frames_seen = 0;
    int target = 0;
    logic [23:0] ref_mem [NLED];
    logic [23:0] exp_words[$];
    int exp_cycles[$];

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // What the strip should see for a stored word.
    function automatic logic [23:0] expect_word(input logic [23:0] w);
`ifdef WS2811_BRIGHTNESS_EN
        int r = 0;
        int b = int'(brightness);
        for (int c = 0; c < 3; c++) begin
            int ch = (int'(w) >> (8 * c)) & 255;
            r = r | (((ch * (b + 1)) / 256) << (8 * c));
        end
        return r[23:0];
`else
        return w;
`endif
    endfunction

    // Monitor: decode pulses into bits/words, check timing and frame length.
    int hi_run = 0, lo_run = 0, hi_prev = 0, bitcnt = 0, bcnt = 0;
    logic [23:0] word = 24'd0;
    logic prev_last = 1'b0, any_bit = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                hi_run = 0; lo_run = 0; hi_prev = 0; bitcnt = 0; bcnt = 0;
                prev_last = 1'b0; any_bit = 1'b0;
            end else begin
                if (busy) bcnt++;
                if (serial) begin
                    if (hi_run == 0) begin
                        if (!any_bit) check("first_rise_delay", bcnt, 2);
                        else check("bit_period", hi_prev + lo_run, prev_last ? 10 : 8);
                    end
                    hi_run++;
                    lo_run = 0;
                end else begin
                    if (hi_run > 0) begin
                        check("pulse_width", hi_run, (hi_run > 3) ? 5 : 2);
                        word = {word[22:0], (hi_run > 3)};
                        bitcnt++;
                        any_bit = 1'b1;
                        hi_prev = hi_run;
                        hi_run = 0;
                        prev_last = 1'b0;
                        if (bitcnt == 24) begin
                            if (exp_words.size() == 0) begin
                                n_checks++; n_fail++;
                                $display("FAIL word_unexpected: got 0x%06h, required none", word);
                            end else begin
                                check("word", word, exp_words.pop_front());
                            end
                            bitcnt = 0;
                            prev_last = 1'b1;
                        end
                    end
                    lo_run++;
                end
                if (frame_done) begin
                    check("busy_low_at_done", busy, 0);
                    check("partial_word", bitcnt, 0);
                    if (exp_cycles.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL frame_unexpected: got frame of %0d busy cycles, required none", bcnt);
                    end else begin
                        check("frame_busy_cycles", bcnt, exp_cycles.pop_front());
                    end
                    if (any_bit) check("latch_gap", lo_run, 30 - hi_prev);
                    bcnt = 0; any_bit = 1'b0; prev_last = 1'b0;
                    frames_seen++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write_led(input int a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a[1:0]; wr_rgb = d;
        tick(1);
        wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic expect_frame(input int cnt);
        int n = (cnt > NLED) ? NLED : cnt;
        for (int k = 0; k < n; k++) exp_words.push_back(expect_word(ref_mem[k]));
        exp_cycles.push_back(FRAME_PER_LED * n + LATCH_LEN);
        target++;
    endtask

    task automatic start_frame(input int cnt);
        expect_frame(cnt);
        led_count = cnt[2:0];
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (frames_seen < target && t < budget) begin
            tick(1);
            t++;
        end
        check("frame_completed", frames_seen, target);
        frames_seen = target;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] old0, new0, new1;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_rgb = 24'd0;
        led_count = 3'd0; start = 1'b0;
        tick(3);
        check("reset_serial", serial, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_state", db_state, 0);
        reset = 1'b0;
        for (int k = 0; k < NLED; k++) write_led(k, 24'd0);

        // Single LED, first bits 1 then 0.
        write_led(0, 24'hA50000);
        start_frame(1);
        wait_done(2000);

        // Count above buffer depth is clamped.
        for (int k = 0; k < NLED; k++) write_led(k, 24'(k + 1));
        start_frame(7);
        wait_done(2000);

        // Empty frame: latch gap only.
        start_frame(0);
        wait_done(200);

        // Start pulses while busy are ignored.
        start_frame(2);
        for (int p = 0; p < 3; p++) begin
            tick(90);
            start = 1'b1; tick(1); start = 1'b0;
        end
        wait_done(2000);
        tick(3);
        check("no_restart_after_ignored_start", busy, 0);

        // Start held high: back-to-back frames.
        expect_frame(1);
        expect_frame(1);
        led_count = 3'd1;
        start = 1'b1;
        tick(1);
        target--;
        wait_done(2000);
        check("restart_after_done", busy, 1);
        start = 1'b0;
        target++;
        wait_done(2000);

        // Mid-frame writes: later LED sees new data, the LED in flight does not.
        old0 = 24'($urandom);
        new0 = 24'($urandom);
        new1 = 24'($urandom);
        write_led(0, old0);
        write_led(1, 24'($urandom));
        exp_words.push_back(expect_word(old0));
        exp_words.push_back(expect_word(new1));
        exp_cycles.push_back(FRAME_PER_LED * 2 + LATCH_LEN);
        target++;
        led_count = 3'd2; start = 1'b1; tick(1); start = 1'b0;
        tick(42);
        write_led(0, new0);
        tick(38);
        write_led(1, new1);
        wait_done(2000);
        start_frame(2);
        wait_done(2000);

        // Asynchronous reset during a high phase.
        write_led(0, 24'hFFFFFF);
        led_count = 3'd2; start = 1'b1; tick(1); start = 1'b0;
        tick(49);
        #2;
        check("serial_high_before_reset", serial, 1);
        reset = 1'b1;
        #1;
        check("async_reset_serial", serial, 0);
        check("async_reset_busy", busy, 0);
        exp_words.delete();
        exp_cycles.delete();
        tick(2);
        reset = 1'b0;
        start_frame(1);
        wait_done(2000);

        // Randomised frames with stray start pulses.
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NLED; k++) write_led(k, 24'($urandom));
            start_frame(int'($urandom_range(0, 7)));
            tick(int'($urandom_range(1, 150)));
            if (busy) begin
                start = 1'b1; tick(1); start = 1'b0;
            end
            wait_done(2000);
            tick(int'($urandom_range(1, 5)));
        end

        write_led(0, 24'hFF8040);
        start_frame(1);
        wait_done(2000);
        tick(5);
        check("queue_words_drained", exp_words.size(), 0);
        check("queue_frames_drained", exp_cycles.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
